// File: rtl/fft_r2_stream_if.sv
// fft_r2_stream_if: sample-in / spectrum-out stream bundle for fft_r2_stream.
//   in_valid/in_ready/in_re/in_im          : time-domain sample stream into the engine
//   out_valid/out_ready/out_re/out_im      : spectrum stream out of the engine, natural order
//   out_idx/out_last                       : bin index of the current output, high on bin N-1
//   busy                                   : engine is transforming or unloading
//   slave  : engine side
//   master : producer/consumer side
interface fft_r2_stream_if #(
   parameter int LOG2N  = 3,
   parameter int DATA_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_re;
   logic signed [DATA_W-1:0] in_im;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_re;
   logic signed [DATA_W-1:0] out_im;
   logic [LOG2N-1:0]         out_idx;
   logic                     out_last;
   logic                     busy;
   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
   );
   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
   );
endinterface

// File: rtl/fft_r2_stream.sv
// fft_r2_stream: iterative radix-2 DIT FFT, one time-shared butterfly per cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   s   : fft_r2_stream_if.slave -- sample input stream, spectrum output stream
//         (with bin index and last marker) and busy flag
// Flow: LOAD (N samples stored bit-reversed) -> COMPUTE (LOG2N*N/2 cycles, in place)
//       -> UNLOAD (bins 0..N-1 in natural order) -> LOAD.
// Optional build macro FFT_STAGE_SCALE_EN: halve every butterfly output (overall 1/N);
// without it each butterfly output saturates and the result is the unscaled DFT.
module fft_r2_stream #(
   parameter int LOG2N  = 3,
   parameter int DATA_W = 16,
   parameter int TW_W   = 16
) (
   input logic            clk,
   input logic            rst,
   fft_r2_stream_if.slave s
);
   localparam int N  = 1 << LOG2N;
   localparam int H  = N / 2;
   localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1;
   localparam int IW = DATA_W + 2;
   localparam int PW = DATA_W + TW_W + 1;
   localparam logic signed [PW-1:0] RND  = PW'(1) << (TW_W - 2);
   localparam logic signed [IW-1:0] SMAX = IW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [IW-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
   typedef logic [H-1:0][TW_W-1:0] tw_rom_t;

   // Round to nearest; +1.0 does not fit Q1.(TW_W-1) and is clamped.
   function automatic logic [TW_W-1:0] tw_q(input real r);
      int v;
      v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      return (v > (1 << (TW_W - 1)) - 1) ? TW_W'((1 << (TW_W - 1)) - 1) : TW_W'(v);
   endfunction

   // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k = 0..N/2-1
   function automatic tw_rom_t tw_gen(input bit imag);
      tw_rom_t rom;
      real     scale;
      real     ang;
      rom   = '0;
      scale = 2.0 ** (TW_W - 1);
      for (int k = 0; k < H; k++) begin
         ang    = 6.283185307179586 * k / N;
         rom[k] = tw_q(imag ? -$sin(ang) * scale : $cos(ang) * scale);
      end
      return rom;
   endfunction

   localparam tw_rom_t TW_RE = tw_gen(1'b0);
   localparam tw_rom_t TW_IM = tw_gen(1'b1);

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [IW-1:0] x);
      logic signed [IW-1:0] y;
`ifdef FFT_STAGE_SCALE_EN
      y = x >>> 1;
`else
      y = x;
`endif
      return (y > SMAX) ? DATA_W'(SMAX) : (y < SMIN) ? DATA_W'(SMIN) : DATA_W'(y);
   endfunction

   state_t                   state, state_n;
   logic [LOG2N-1:0]         cnt, rev, j, lo_mask, half, lo, a, b;
   logic [KW-1:0]            kh;
   logic [3:0]               stage;
   logic                     k0, last_j, last_stage, load_hs, unload_hs;
   logic signed [DATA_W-1:0] mem_re [N];
   logic signed [DATA_W-1:0] mem_im [N];
   logic signed [DATA_W-1:0] ar, ai, br, bi, sa_re, sa_im, sb_re, sb_im;
   logic signed [TW_W-1:0]   wr, wi;
   logic signed [PW-1:0]     pr, pi;
   logic signed [IW-1:0]     tr, ti;

   assign load_hs    = state == LOAD && s.in_valid;
   assign unload_hs  = state == UNLOAD && s.out_ready;
   assign last_j     = j == LOG2N'(H - 1);
   assign last_stage = stage == 4'(LOG2N - 1);
   assign rev        = {<<{cnt}};

   // Butterfly j of stage s: a = (j>>s)<<(s+1) | (j mod 2^s), b = a + 2^s,
   // twiddle index k = (j mod 2^s) << (LOG2N-1-s).
   assign lo_mask = LOG2N'((1 << stage) - 1);
   assign half    = LOG2N'(1 << stage);
   assign lo      = j & lo_mask;
   assign a       = ((j & ~lo_mask) << 1) | lo;
   assign b       = a | half;
   assign kh      = KW'(lo << (LOG2N - 1 - stage));
   assign k0      = lo == '0;

   assign ar = mem_re[a];
   assign ai = mem_im[a];
   assign br = mem_re[b];
   assign bi = mem_im[b];
   assign wr = TW_RE[kh];
   assign wi = TW_IM[kh];

   // Full-precision complex product, round half up, drop TW_W-1 fraction bits.
   assign pr = br * wr - bi * wi + RND;
   assign pi = br * wi + bi * wr + RND;
   assign tr = k0 ? IW'(br) : IW'(pr >>> (TW_W - 1));
   assign ti = k0 ? IW'(bi) : IW'(pi >>> (TW_W - 1));

   assign sa_re = sat(IW'(ar) + tr);
   assign sa_im = sat(IW'(ai) + ti);
   assign sb_re = sat(IW'(ar) - tr);
   assign sb_im = sat(IW'(ai) - ti);

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= LOAD;
      else     state <= state_n;

   always_comb begin
      state_n     = state == LOAD    ? (load_hs && &cnt ? COMPUTE : LOAD) :
                    state == COMPUTE ? (last_j && last_stage ? UNLOAD : COMPUTE) :
                    state == UNLOAD  ? (unload_hs && &cnt ? LOAD : UNLOAD) : LOAD;
      s.in_ready  = state == LOAD;
      s.out_valid = state == UNLOAD;
      s.busy      = state == COMPUTE || state == UNLOAD;
      s.out_last  = state == UNLOAD && &cnt;
      s.out_idx   = state == UNLOAD ? cnt : '0;
      s.out_re    = state == UNLOAD ? mem_re[cnt] : '0;
      s.out_im    = state == UNLOAD ? mem_im[cnt] : '0;
   end

   // cnt is the load sample counter and then the unload bin index; it wraps to 0
   // on the final handshake of each phase.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt   <= '0;
         j     <= '0;
         stage <= '0;
      end else begin
         if (load_hs || unload_hs) cnt <= cnt + 1'b1;
         if (state == COMPUTE) begin
            j <= last_j ? '0 : j + 1'b1;
            if (last_j) stage <= last_stage ? '0 : stage + 1'b1;
         end
      end

   always_ff @(posedge clk)
      if (load_hs) begin
         mem_re[rev] <= s.in_re;
         mem_im[rev] <= s.in_im;
      end else if (state == COMPUTE) begin
         mem_re[a] <= sa_re;
         mem_im[a] <= sa_im;
         mem_re[b] <= sb_re;
         mem_im[b] <= sb_im;
      end
endmodule

// File: tb/tb_fft_r2_stream.sv
// tb_fft_r2_stream: directed-vector bench for fft_r2_stream at N=8, DATA_W=16, TW_W=16.
module tb_fft_r2_stream;
`ifdef FFT_STAGE_SCALE_EN
   localparam int SC  = 8;
   localparam int DC0 = 5000;
`else
   localparam int SC  = 1;
   localparam int DC0 = 32767;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   xr [8];
   int   xi [8];
   int   er [8];
   int   ei [8];

   fft_r2_stream_if #(.LOG2N(3), .DATA_W(16)) io ();
   fft_r2_stream #(.LOG2N(3), .DATA_W(16), .TW_W(16)) dut (.clk(clk), .rst(rst), .s(io.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp, input int tol);
      n_vec++;
      assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   // Sends xr/xi; with gaps, in_valid drops for a cycle carrying junk data before odd samples.
   task automatic send(input bit gaps);
      for (int n = 0; n < 8; n++) begin
         if (gaps && (n % 2 == 1)) begin
            io.in_valid = 1'b0;
            io.in_re    = 16'sh1234;
            io.in_im    = -16'sd777;
            tick();
         end
         io.in_valid = 1'b1;
         io.in_re    = 16'(xr[n]);
         io.in_im    = 16'(xi[n]);
         for (int t = 0; t < 50 && !io.in_ready; t++) tick();
         chk("in_ready", io.in_ready, 1);
         tick();
      end
      io.in_valid = 1'b0;
      io.in_re    = '0;
      io.in_im    = '0;
      last_acc    = cyc;
   endtask

   // Receives 8 bins against er/ei; stalls out_ready for 5 cycles at bin 'stall'.
   task automatic recv(input int tol, input int stall);
      for (int i = 0; i < 8; i++) begin
         for (int t = 0; t < 100 && !io.out_valid; t++) tick();
         chk("out_valid", io.out_valid, 1);
         chk("out_idx", io.out_idx, i);
         chk("out_last", io.out_last, i == 7);
         chk_tol($sformatf("bin%0d_re", i), io.out_re, er[i], tol);
         chk_tol($sformatf("bin%0d_im", i), io.out_im, ei[i], tol);
         if (i == stall) begin
            io.out_ready = 1'b0;
            repeat (5) begin
               tick();
               chk("stall_valid", io.out_valid, 1);
               chk("stall_idx", io.out_idx, i);
               chk_tol("stall_re", io.out_re, er[i], tol);
               chk_tol("stall_im", io.out_im, ei[i], tol);
            end
            io.out_ready = 1'b1;
         end
         tick();
      end
      chk("done_valid", io.out_valid, 0);
      chk("done_in_ready", io.in_ready, 1);
      chk("done_busy", io.busy, 0);
   endtask

   initial begin
      io.in_valid  = 1'b0;
      io.in_re     = '0;
      io.in_im     = '0;
      io.out_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready", io.in_ready, 1);
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_out_last", io.out_last, 0);
      chk("rst_busy", io.busy, 0);
      chk("rst_out_idx", io.out_idx, 0);
      chk("rst_out_re", io.out_re, 0);
      chk("rst_out_im", io.out_im, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // impulse at n=0 with gapped input and backpressure at bin 3
      xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
      xi = '{default: 0};
      er = '{default: 1000 / SC};
      ei = '{default: 0};
      send(1'b1);
      recv(0, 3);

      // DC 5000: bin 0 overflows the unscaled range
      xr = '{default: 5000};
      xi = '{default: 0};
      er = '{DC0, 0, 0, 0, 0, 0, 0, 0};
      ei = '{default: 0};
      send(1'b0);
      recv(0, -1);

      // alternating +/-800 -> energy only in bin 4; check compute latency and busy
      xr = '{800, -800, 800, -800, 800, -800, 800, -800};
      xi = '{default: 0};
      er = '{0, 0, 0, 0, 6400 / SC, 0, 0, 0};
      ei = '{default: 0};
      send(1'b0);
      for (int t = 0; t < 100 && !io.out_valid; t++) begin
         chk("compute_busy", io.busy, 1);
         chk("compute_in_ready", io.in_ready, 0);
         tick();
      end
      chk("latency", cyc - last_acc, 12);
      recv(0, -1);

      // impulse at n=1 -> X[k] = 1000*exp(-j*2*pi*k/8), exercises every twiddle
      xr = '{0, 1000, 0, 0, 0, 0, 0, 0};
      xi = '{default: 0};
      er = '{1000 / SC, 707 / SC, 0, -707 / SC, -1000 / SC, -707 / SC, 0, 707 / SC};
      ei = '{0, -707 / SC, -1000 / SC, -707 / SC, 0, 707 / SC, 1000 / SC, 707 / SC};
      send(1'b0);
      recv(2, -1);

      // asynchronous reset six cycles into COMPUTE, then a clean impulse block
      xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
      xi = '{default: 0};
      send(1'b0);
      repeat (6) tick();
      chk("mid_busy", io.busy, 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", io.busy, 0);
      chk("arst_in_ready", io.in_ready, 1);
      chk("arst_out_valid", io.out_valid, 0);
      chk("arst_out_idx", io.out_idx, 0);
      chk("arst_out_re", io.out_re, 0);
      #2 rst = 1'b0;
      tick();
      chk("post_rst_out_valid", io.out_valid, 0);
      chk("post_rst_busy", io.busy, 0);
      er = '{default: 1000 / SC};
      ei = '{default: 0};
      send(1'b0);
      recv(0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
